// File: rtl/ele_disp.sv
// ele_disp: 4-digit multiplexed elevator status display with a burst beeper.
// Digit 3 = floor, 2 = direction glyph, 1 = seconds (dp lit), 0 = tenths.
module ele_disp #(
  parameter int unsigned SCAN_DIV  = 16,
  parameter int unsigned BEEP_HALF = 4,
  parameter int unsigned BURST_LEN = 32,
  parameter int unsigned BURST_CNT = 3
) (
  input  logic       clk,
  input  logic       sysclr_n,
  input  logic       en,
  input  logic [1:0] floor,
  input  logic       state_down,
  input  logic       state_stay,
  input  logic       state_up,
  input  logic [3:0] cnt_s_disp,
  input  logic [3:0] cnt_ms_disp,
  input  logic       beep_en,
  output logic [7:0] seg,
  output logic [3:0] dig_sel,
  output logic       beep,
  output logic       err
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned HW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam int unsigned LW = $clog2(BURST_LEN);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(BEEP_HALF - 1);
  localparam logic [LW-1:0] LEN_LAST  = LW'(BURST_LEN - 1);
  localparam logic [3:0]    BURSTS    = 4'(BURST_CNT);

  typedef struct packed {
    logic [1:0] floor;
    logic       up;
    logic       stay;
    logic       down;
    logic [3:0] s;
    logic [3:0] ms;
  } snap_t;

  localparam snap_t SNAP_RST = '{floor: 2'd0, up: 1'b0, stay: 1'b1, down: 1'b0,
                                 s: 4'd0, ms: 4'd0};

  typedef enum logic [1:0] {IDLE, TONE, GAP} beep_state_e;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  snap_t         snap_q, snap_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_sel_q, dig_sel_d;
  logic          err_q, err_d;
  logic          been_q, been_d;
  beep_state_e   state_q, state_d;
  logic [LW-1:0] cyc_q, cyc_d;
  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic [3:0]    burst_q, burst_d;
  logic          beep_d;
  logic          rise;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic dir_bad(input snap_t s);
    case ({s.up, s.stay, s.down})
      3'b100, 3'b010, 3'b001: return 1'b0;
      default:                return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] dir_glyph(input snap_t s);
    case ({s.up, s.stay, s.down})
      3'b100:  return 8'hFE;
      3'b010:  return 8'hBF;
      3'b001:  return 8'hF7;
      default: return 8'h86;
    endcase
  endfunction

  // All state registers
  always_ff @(posedge clk or negedge sysclr_n) begin
    if (!sysclr_n) begin
      div_q     <= '0;
      idx_q     <= 2'd3;
      snap_q    <= SNAP_RST;
      seg_q     <= '1;
      dig_sel_q <= '1;
      err_q     <= 1'b0;
      been_q    <= 1'b0;
      state_q   <= IDLE;
      cyc_q     <= '0;
      half_q    <= '0;
      phase_q   <= 1'b0;
      burst_q   <= '0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
      err_q     <= err_d;
      been_q    <= been_d;
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      half_q    <= half_d;
      phase_q   <= phase_d;
      burst_q   <= burst_d;
    end
  end

  // Scan divider, digit index and frame snapshot
  always_comb begin
    div_d  = div_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (!en) begin
      div_d = '0;
      idx_d = 2'd3;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q - 2'd1;
    end else begin
      div_d = div_q + DW'(1);
    end
    // Loading at the last slot of digit 0 keeps a whole frame coherent.
    if (!en || (div_q == DIV_LAST && idx_q == 2'd0)) begin
      snap_d = {floor, state_up, state_stay, state_down, cnt_s_disp, cnt_ms_disp};
    end
    err_d = dir_bad(snap_q);
  end

  // Registered digit select and segment content
  always_comb begin
    dig_sel_d = '1;
    seg_d     = '1;
    if (en) begin
      dig_sel_d = ~(4'b0001 << idx_q);
      case (idx_q)
        2'd3:    seg_d = bcd_to_seg({2'b00, snap_q.floor} + 4'd1);
        2'd2:    seg_d = dir_glyph(snap_q);
        2'd1:    seg_d = bcd_to_seg(snap_q.s) & 8'h7F;
        default: seg_d = bcd_to_seg(snap_q.ms);
      endcase
    end
  end

  assign been_d = beep_en;
  assign rise   = beep_en && !been_q;

  // Beep FSM next state and burst counters
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    half_d  = half_q;
    phase_d = phase_q;
    burst_d = burst_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = TONE;
            cyc_d   = '0;
            half_d  = '0;
            phase_d = 1'b1;
            burst_d = '0;
          end
        end
        TONE: begin
          if (half_q == HALF_LAST) begin
            half_d  = '0;
            phase_d = ~phase_q;
          end else begin
            half_d = half_q + HW'(1);
          end
          if (cyc_q == LEN_LAST) begin
            cyc_d   = '0;
            burst_d = burst_q + 4'd1;
            state_d = ((burst_q + 4'd1) == BURSTS) ? IDLE : GAP;
          end else begin
            cyc_d = cyc_q + LW'(1);
          end
        end
        GAP: begin
          if (cyc_q == LEN_LAST) begin
            state_d = TONE;
            cyc_d   = '0;
            half_d  = '0;
            phase_d = 1'b1;
          end else begin
            cyc_d = cyc_q + LW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Beep FSM output
  always_comb begin
    beep_d = (state_q == TONE) && phase_q;
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;
  assign err     = err_q;
  assign beep    = beep_d;

endmodule
